// File: rtl/irq_ctrl.sv
// Interrupt controller: per-channel enable and edge/level capture, fixed-priority
// arbitration (lowest index wins), vector ID with ack handshake, bus-mapped registers.
module irq_ctrl #(
  parameter int unsigned NUM_IRQ   = 8,
  parameter logic [15:0] BASE_ADDR = 16'h1100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        address,
  input  logic [7:0]         din,
  input  logic               w_en,
  input  logic               r_en,
  output logic [7:0]         dout,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic [NUM_IRQ-1:0] irq_src_clr,
  output logic               irq_req,
  output logic [2:0]         irq_id,
  input  logic               irq_ack
);

  localparam logic [15:0] AddrEnable  = BASE_ADDR;
  localparam logic [15:0] AddrMode    = BASE_ADDR + 16'd1;
  localparam logic [15:0] AddrPending = BASE_ADDR + 16'd2;
  localparam logic [15:0] AddrStatus  = BASE_ADDR + 16'd3;
  localparam logic [15:0] AddrSwtrig  = BASE_ADDR + 16'd4;

  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] clr_q, clr_d;
  logic [7:0]         dout_q, dout_d;
  logic               req_q, req_d;
  logic [2:0]         id_q, id_d;

  logic sel_enable, sel_mode, sel_pending, sel_status, sel_swtrig;
  logic [NUM_IRQ-1:0] din_ch;
  logic [NUM_IRQ-1:0] set_hw, set_sw, set_all;
  logic [NUM_IRQ-1:0] w1c, ack_vec, act;
  logic               ack_valid;
  logic [2:0]         win_id;
  logic [7:0]         enable_rd, mode_rd, pending_rd, status_rd;

  // Address decode
  always_comb begin
    sel_enable  = (address == AddrEnable);
    sel_mode    = (address == AddrMode);
    sel_pending = (address == AddrPending);
    sel_status  = (address == AddrStatus);
    sel_swtrig  = (address == AddrSwtrig);
    din_ch      = din[NUM_IRQ-1:0];
  end

  // Source capture: edge mode wants a rising edge, level mode just the flag
  always_comb begin
    set_hw  = irq_src & ~(mode_q & src_q);
    set_sw  = (w_en && sel_swtrig) ? din_ch : '0;
    set_all = set_hw | set_sw;
  end

  // Ack only counts while a request is actually presented
  always_comb begin
    ack_valid = irq_ack & req_q;
    ack_vec   = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      ack_vec[i] = ack_valid && (id_q == 3'(i));
    end
    w1c = (w_en && sel_pending) ? din_ch : '0;
  end

  // Set beats clear, so a fresh event coinciding with its ack is never lost
  always_comb begin
    clr_d     = ack_vec | w1c;
    pending_d = set_all | (pending_q & ~clr_d);
    enable_d  = (w_en && sel_enable) ? din_ch : enable_q;
    mode_d    = (w_en && sel_mode) ? din_ch : mode_q;
  end

  // Fixed priority: scan downwards so the lowest active index is the last assignment
  always_comb begin
    act    = pending_q & enable_q;
    win_id = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (act[i]) begin
        win_id = 3'(i);
      end
    end
    req_d = |act;
    id_d  = req_d ? win_id : id_q;
  end

  // Byte-wide register views; bits at and above NUM_IRQ read as zero
  always_comb begin
    enable_rd                 = '0;
    mode_rd                   = '0;
    pending_rd                = '0;
    enable_rd[NUM_IRQ-1:0]    = enable_q;
    mode_rd[NUM_IRQ-1:0]      = mode_q;
    pending_rd[NUM_IRQ-1:0]   = pending_q;
    status_rd                 = {req_q, 4'b0000, id_q};
  end

  always_comb begin
    dout_d = '0;
    if (r_en) begin
      if (sel_enable) begin
        dout_d = enable_rd;
      end else if (sel_mode) begin
        dout_d = mode_rd;
      end else if (sel_pending) begin
        dout_d = pending_rd;
      end else if (sel_status) begin
        dout_d = status_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      src_q     <= '0;
      clr_q     <= '0;
      dout_q    <= '0;
      req_q     <= 1'b0;
      id_q      <= '0;
    end else begin
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      src_q     <= irq_src;
      clr_q     <= clr_d;
      dout_q    <= dout_d;
      req_q     <= req_d;
      id_q      <= id_d;
    end
  end

  assign dout        = dout_q;
  assign irq_src_clr = clr_q;
  assign irq_req     = req_q;
  assign irq_id      = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected read data, clear pulses and
// request snapshots; a negedge monitor pops and compares as the DUT presents them.
module tb_irq_ctrl;

  localparam logic [15:0] Base = 16'h1100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  din = '0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [7:0]  dout;
  logic [7:0]  irq_src = '0;
  logic [7:0]  irq_src_clr;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic        irq_ack = 1'b0;

  irq_ctrl #(
    .NUM_IRQ  (8),
    .BASE_ADDR(Base)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .din        (din),
    .w_en       (w_en),
    .r_en       (r_en),
    .dout       (dout),
    .irq_src    (irq_src),
    .irq_src_clr(irq_src_clr),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  typedef struct {
    string      name;
    logic       req;
    logic [2:0] id;
    bit         chk_dout;
    logic [7:0] dout;
  } probe_t;

  exp_t   rd_q[$];
  exp_t   clr_q[$];
  probe_t pr_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  logic   probe = 1'b0;
  logic   rd_pend;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Read data appears the cycle after the strobe
  always @(posedge clk or negedge rst) begin
    if (!rst) rd_pend <= 1'b0;
    else      rd_pend <= r_en;
  end

  always @(negedge clk) begin
    exp_t   e;
    probe_t p;
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        check("read_unexpected", dout, 8'hxx);
      end else begin
        e = rd_q.pop_front();
        check(e.name, dout, e.val);
      end
    end
    if (irq_src_clr != 8'h00) begin
      if (clr_q.size() == 0) begin
        check("clr_unexpected", irq_src_clr, 8'h00);
      end else begin
        e = clr_q.pop_front();
        check(e.name, irq_src_clr, e.val);
      end
    end
    if (probe && pr_q.size() != 0) begin
      p = pr_q.pop_front();
      check({p.name, "_req"}, {7'b0, irq_req}, {7'b0, p.req});
      check({p.name, "_id"}, {5'b0, irq_id}, {5'b0, p.id});
      if (p.chk_dout) check({p.name, "_dout"}, dout, p.dout);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_irq(input string name, input logic req, input logic [2:0] id);
    probe_t p;
    p.name = name; p.req = req; p.id = id; p.chk_dout = 1'b0; p.dout = '0;
    pr_q.push_back(p);
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic expect_clr(input string name, input logic [7:0] val);
    exp_t e;
    e.name = name; e.val = val;
    clr_q.push_back(e);
  endtask

  task automatic wr(input logic [15:0] off, input logic [7:0] data);
    address = Base + off; din = data; w_en = 1'b1;
    cyc();
    w_en = 1'b0;
  endtask

  task automatic rd(input string name, input logic [15:0] off, input logic [7:0] exp);
    exp_t e;
    e.name = name; e.val = exp;
    rd_q.push_back(e);
    address = Base + off; r_en = 1'b1;
    cyc();
    r_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    probe_t p;
    // Reset held with all sources high
    irq_src = 8'hFF;
    repeat (3) cyc();
    p.name = "reset"; p.req = 1'b0; p.id = 3'd0; p.chk_dout = 1'b1; p.dout = 8'h00;
    pr_q.push_back(p);
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();
    cyc();
    expect_irq("masked_after_reset", 1'b0, 3'd0);
    rd("pending_level_ff", 16'd2, 8'hFF);
    rd("status_idle", 16'd3, 8'h00);
    irq_src = 8'h00;
    expect_clr("w1c_all", 8'hFF);
    wr(16'd2, 8'hFF);

    // Edge pulse on ch5
    wr(16'd0, 8'hFF);
    wr(16'd1, 8'hFF);
    irq_src = 8'h20;
    cyc();
    irq_src = 8'h00;
    expect_irq("ch5_latency_n1", 1'b0, 3'd0);
    cyc();
    expect_irq("ch5_req", 1'b1, 3'd5);
    expect_clr("ch5_ack_clr", 8'h20);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    cyc();
    expect_irq("ch5_req_drop", 1'b0, 3'd5);

    // Priority between ch6 and ch2
    irq_src = 8'h44;
    cyc();
    irq_src = 8'h00;
    cyc();
    expect_irq("prio_ch2", 1'b1, 3'd2);
    expect_clr("ack_ch2", 8'h04);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    cyc();
    expect_irq("prio_ch6", 1'b1, 3'd6);
    expect_clr("ack_ch6", 8'h40);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    cyc();
    expect_irq("prio_done", 1'b0, 3'd6);
    rd("status_id_hold", 16'd3, 8'h06);

    // Level mode ch0, source held through ack
    wr(16'd1, 8'hFE);
    irq_src = 8'h01;
    cyc();
    cyc();
    expect_irq("lvl_req", 1'b1, 3'd0);
    expect_clr("lvl_ack1", 8'h01);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    irq_src = 8'h00;
    rd("lvl_reset_pending", 16'd2, 8'h01);
    expect_clr("lvl_ack2", 8'h01);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    cyc();
    expect_irq("lvl_drop", 1'b0, 3'd0);

    // Software trigger and W1C
    wr(16'd4, 8'h08);
    rd("swtrig_pending", 16'd2, 8'h08);
    expect_irq("swtrig_req", 1'b1, 3'd3);
    expect_clr("w1c_ch3", 8'h08);
    wr(16'd2, 8'h08);
    cyc();
    expect_irq("w1c_drop", 1'b0, 3'd3);

    // Ack with no request is ignored
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    cyc();
    expect_irq("ack_ignored", 1'b0, 3'd3);

    // New edge on ch3 coincident with its ack
    wr(16'd1, 8'hFF);
    irq_src = 8'h08;
    cyc();
    irq_src = 8'h00;
    cyc();
    irq_src = 8'h08;
    irq_ack = 1'b1;
    expect_clr("ack_set_ch3", 8'h08);
    cyc();
    irq_ack = 1'b0;
    irq_src = 8'h00;
    cyc();
    expect_irq("ack_set_req", 1'b1, 3'd3);
    rd("ack_set_pending", 16'd2, 8'h08);
    expect_clr("ack_ch3_final", 8'h08);
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    cyc();
    cyc();

    // Same-cycle read/write, unmapped read, masking
    begin
      exp_t e;
      e.name = "rw_pre_write"; e.val = 8'hFF;
      rd_q.push_back(e);
      address = Base; din = 8'h55; w_en = 1'b1; r_en = 1'b1;
      cyc();
      w_en = 1'b0; r_en = 1'b0;
    end
    rd("enable_55", 16'd0, 8'h55);
    rd("swtrig_reads_0", 16'd4, 8'h00);
    rd("out_of_range", 16'd5, 8'h00);
    wr(16'd4, 8'h02);
    cyc();
    cyc();
    expect_irq("mask_ch1", 1'b0, 3'd3);
    rd("mask_pending", 16'd2, 8'h02);
    wr(16'd0, 8'h57);
    cyc();
    expect_irq("unmask_ch1", 1'b1, 3'd1);
    expect_clr("w1c_ch1", 8'h02);
    wr(16'd2, 8'h02);
    cyc();
    cyc();
    expect_irq("unmask_drop", 1'b0, 3'd1);

    repeat (3) cyc();
    check("clr_queue_drained", 8'(clr_q.size()), 8'd0);
    check("rd_queue_drained", 8'(rd_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
